pixel_sink: RTL and testbench
=============================

// Module: pixel_sink
// PURPOSE
// Receiving end of the pixel-plot stream (x, y, colour, plot) emitted by the bird/hunter draw
// FSMs. Buffers plot requests in a small FIFO, drops off-screen pixels, converts (x,y) to a
// linear address and writes them into the 160x120 framebuffer write port. Also performs a
// full-screen clear on request (game reset). Sits between the draw controller and framebuffer.
// PARAMETERS
// WIDTH         160     screen width in pixels
// HEIGHT        120     screen height in pixels
// DEPTH_LOG2    3       FIFO depth = 2**DEPTH_LOG2 entries (8)
// CLEAR_COLOUR  3'b000  colour written during clear
// PORTS
// clock        in   1   system clock (CLOCK_50 at top)
// resetn       in   1   asynchronous reset, active-low
// plot         in   1   pixel request valid; accepted on a clock edge only when in_ready=1
// x            in   8   pixel column
// y            in   7   pixel row
// colour       in   3   pixel colour {R,G,B}
// in_ready     out  1   FIFO not full and not clearing
// clear_req    in   1   pulse: start full-screen clear
// busy         out  1   clear in progress or FIFO non-empty
// mem_addr     out  15  framebuffer address = y*WIDTH + x
// mem_data     out  3   framebuffer write data
// mem_wren     out  1   write strobe, one pixel per cycle it is high
// mem_ready    in   1   framebuffer can accept a write this cycle
// drop_count   out  8   saturating count of off-screen requests discarded
// BEHAVIOUR
// - Reset (resetn=0, async): FIFO empty, state IDLE, mem_wren=0, mem_addr=0, mem_data=0,
//   drop_count=0, in_ready=0 while resetn low, 1 on first cycle after release, busy=0.
// - Accept: plot && in_ready at posedge. If x>=WIDTH or y>=HEIGHT (e.g. x=8'hFF idle value)
//   the request is discarded, not enqueued; drop_count+1, saturating at 255.
// - FIFO: registered read/write pointers of DEPTH_LOG2+1 bits; full when MSBs differ and
//   low bits equal; empty when equal. Simultaneous push and pop on a full FIFO: pop
//   frees space only next cycle, so in_ready stays 0 that cycle (no bypass).
// - Drain: in IDLE, when FIFO non-empty, present head as registered outputs: mem_wren=1,
//   mem_addr=y*160+x (computed as (y<<7)+(y<<5)+x, 15 bits, max 19199), mem_data=colour.
//   Entry pops on the edge where mem_wren && mem_ready; outputs hold stable while
//   mem_ready=0. Latency: accepted pixel into empty FIFO -> mem_wren high 2 cycles later.
// - Ordering: pixels written in exact acceptance order (erase before redraw is preserved).
// - States: IDLE (drain FIFO) -> FLUSH on clear_req (stop accepting, finish FIFO) ->
//   CLEAR when FIFO empty and no write pending -> IDLE after address 19199 written.
// - CLEAR: 15-bit counter from 0, mem_data=CLEAR_COLOUR, mem_wren=1, counter advances only on
//   mem_ready. Exactly WIDTH*HEIGHT writes, no wrap past 19199.
// - clear_req while already FLUSH/CLEAR: ignored. clear_req and plot same cycle: the plot
//   is accepted (in_ready was 1) and drawn before the clear.
// - Reset mid-CLEAR or mid-drain: abort immediately, FIFO contents lost, return to IDLE.
// - busy = (state!=IDLE) || !empty || mem_wren.
// TESTING
// 1 plot x=5,y=10,col=7, mem_ready=1 -> 2 cycles later mem_wren=1, addr=1605, data=7, one cycle.
// 2 9 back-to-back plots, mem_ready=0 -> in_ready drops after 8th; 9th held; raise
//   mem_ready -> 8 writes in order, then 9th accepted and written.
// 3 plot x=255,y=127 and x=160,y=0 -> no mem_wren, drop_count=2; 300 drops -> saturates 255.
// 4 3 plots queued then clear_req -> 3 pixel writes, then 19200 writes data=0, addr 0..19199,
//   busy falls the cycle after last write; in_ready=0 throughout.
// 5 resetn low at CLEAR addr 500 -> mem_wren=0 asynchronously, state IDLE, FIFO empty.
// 6 random plots with random mem_ready toggling -> scoreboard: write sequence equals
//   accepted on-screen sequence, no duplicates, no loss.

Source files
------------

// File: rtl/pixel_sink_if.sv
// Pixel-plot stream between the draw FSMs (master) and the pixel sink (slave).
interface pixel_sink_if;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       in_ready;

    modport master (output plot, output x, output y, output colour, input in_ready);
    modport slave  (input plot, input x, input y, input colour, output in_ready);
endinterface

// File: rtl/pixel_sink.sv
// Pixel sink: queues plot requests, discards off-screen pixels, writes the rest to the
// framebuffer in acceptance order, and runs a full-screen clear on request.
//
// state | meaning
// IDLE  | accept plots, drain FIFO to the framebuffer
// FLUSH | clear requested: plots refused, FIFO drained
// CLEAR | write CLEAR_COLOUR to every address 0..WIDTH*HEIGHT-1
module pixel_sink #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter int         DEPTH_LOG2   = 3,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clock,
    input  logic        resetn,
    pixel_sink_if.slave pix,
    input  logic        clear_req,
    output logic        busy,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_wren,
    input  logic        mem_ready,
    output logic [7:0]  drop_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [7:0]          X_LIM     = 8'(WIDTH);
    localparam logic [6:0]          Y_LIM     = 7'(HEIGHT);
    localparam logic [14:0]         LAST_ADDR = 15'(WIDTH * HEIGHT - 1);
    localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [17:0]           fifo_mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2:0]   fill;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] rd_idx_nxt;
    logic                  empty;
    logic                  full;
    logic                  more_than_one;
    logic                  accept;
    logic                  on_screen;
    logic                  push;
    logic                  pop;
    logic [14:0]           lin_addr;

    assign empty         = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                           (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign fill          = wr_ptr - rd_ptr;
    assign more_than_one = (fill > PTR_ONE);
    assign rd_idx        = rd_ptr[DEPTH_LOG2-1:0];
    assign rd_idx_nxt    = rd_idx + PTR_ONE[DEPTH_LOG2-1:0];

    // Uses registered pointers only, so a pop on a full FIFO frees space one cycle later.
    assign pix.in_ready = resetn && !full && (state == S_IDLE);
    assign accept       = pix.plot && pix.in_ready;
    assign on_screen    = (pix.x < X_LIM) && (pix.y < Y_LIM);
    assign push         = accept && on_screen;
    assign pop          = mem_wren && mem_ready && (state != S_CLEAR);

    // y*160 + x as shifts; the address is computed once on entry to the FIFO.
    assign lin_addr = {1'b0, pix.y, 7'b0} + {3'b0, pix.y, 5'b0} + {7'b0, pix.x};

    assign busy = (state != S_IDLE) || !empty || mem_wren;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[DEPTH_LOG2-1:0]] <= {lin_addr, pix.colour};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drop_count <= 8'd0;
        end else if (accept && !on_screen && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // The head entry stays in the FIFO while presented; on a pop the next entry is
    // loaded straight away so back-to-back writes need no bubble.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            mem_addr <= 15'd0;
            mem_data <= 3'd0;
            mem_wren <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FLUSH: begin
                    if ((state == S_IDLE) && clear_req) begin
                        state <= S_FLUSH;
                    end
                    if (pop) begin
                        if (more_than_one) begin
                            {mem_addr, mem_data} <= fifo_mem[rd_idx_nxt];
                        end else begin
                            mem_wren <= 1'b0;
                        end
                    end else if (!mem_wren && !empty) begin
                        {mem_addr, mem_data} <= fifo_mem[rd_idx];
                        mem_wren             <= 1'b1;
                    end else if ((state == S_FLUSH) && empty && !mem_wren) begin
                        state    <= S_CLEAR;
                        mem_addr <= 15'd0;
                        mem_data <= CLEAR_COLOUR;
                        mem_wren <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (mem_ready) begin
                        if (mem_addr == LAST_ADDR) begin
                            state    <= S_IDLE;
                            mem_addr <= 15'd0;
                            mem_wren <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + 15'd1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    mem_wren <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_sink.sv
// Scoreboard bench for pixel_sink: stimulus pushes expected framebuffer writes, a
// negedge monitor pops and compares every committed write.
module tb_pixel_sink;
    logic        clock;
    logic        resetn;
    logic        clear_req;
    logic        busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic        mem_ready;
    logic [7:0]  drop_count;

    pixel_sink_if pix();

    pixel_sink dut (
        .clock      (clock),
        .resetn     (resetn),
        .pix        (pix),
        .clear_req  (clear_req),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_ready  (mem_ready),
        .drop_count (drop_count)
    );

    int          total = 0;
    int          bad = 0;
    int          exp_drop = 0;
    logic [17:0] sb[$];
    bit          done6;
    bit          finished;
    bit          bad_ready;
    bit          bad_busy;
    bit          hit;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one plot and hold it until accepted; the model decides on-screen vs dropped.
    task automatic send(input int xs, input int ys, input int cs);
        bit done = 0;
        pix.plot   = 1'b1;
        pix.x      = 8'(xs);
        pix.y      = 7'(ys);
        pix.colour = 3'(cs);
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clock);
            if (pix.in_ready) begin
                if (xs < 160 && ys < 120) sb.push_back({15'(ys * 160 + xs), 3'(cs)});
                else if (exp_drop < 255) exp_drop++;
                done = 1;
            end
            tick();
        end
        pix.plot = 1'b0;
        pix.x    = 8'hFF;
        pix.y    = 7'h7F;
        if (!done) check("send_timeout", 32'(done), 1);
    endtask

    always @(negedge clock) begin
        if (resetn && mem_wren && mem_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%0d expected=none", mem_addr, mem_data);
            end else begin
                logic [17:0] e;
                e = sb.pop_front();
                if ({mem_addr, mem_data} !== e) begin
                    bad++;
                    $display("FAIL write addr=%0d data=%0d expected addr=%0d data=%0d",
                             mem_addr, mem_data, e[17:3], e[2:0]);
                end
            end
        end
    end

    initial begin
        resetn     = 1'b0;
        clear_req  = 1'b0;
        mem_ready  = 1'b1;
        pix.plot   = 1'b0;
        pix.x      = 8'hFF;
        pix.y      = 7'h7F;
        pix.colour = 3'd0;
        #1;
        check("rst_in_ready", 32'(pix.in_ready), 0);
        check("rst_wren", 32'(mem_wren), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_data), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_busy", 32'(busy), 0);
        #1 resetn = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(pix.in_ready), 1);

        // single plot latency
        send(5, 10, 7);
        check("t1_wren_c1", 32'(mem_wren), 0);
        tick();
        check("t1_wren_c2", 32'(mem_wren), 1);
        check("t1_addr", 32'(mem_addr), 1605);
        check("t1_data", 32'(mem_data), 7);
        tick();
        check("t1_wren_one_cycle", 32'(mem_wren), 0);

        // fill FIFO with the framebuffer stalled
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(i * 10 + 1, i + 2, i % 8);
        check("t2_full_in_ready", 32'(pix.in_ready), 0);
        fork
            send(91, 10, 0);
            begin
                repeat (3) tick();
                mem_ready = 1'b1;
            end
        join
        for (int n = 0; n < 100 && busy; n++) tick();
        check("t2_drained_busy", 32'(busy), 0);
        check("t2_sb_empty", 32'(sb.size()), 0);

        // off-screen drops, corner pixel, saturation
        check("t3_drop_start", 32'(drop_count), 0);
        send(255, 127, 1);
        send(160, 0, 2);
        check("t3_drop2", 32'(drop_count), 2);
        check("t3_no_wren", 32'(mem_wren), 0);
        send(0, 120, 3);
        send(159, 119, 5);
        repeat (3) tick();
        check("t3_drop3", 32'(drop_count), 3);
        for (int i = 0; i < 300; i++) send(200, 5, 1);
        check("t3_drop_sat", 32'(drop_count), 255);
        check("t3_drop_model", 32'(drop_count), 32'(exp_drop));

        // queued pixels then full clear; plot and clear_req share a cycle
        mem_ready = 1'b0;
        send(1, 0, 6);
        send(2, 0, 4);
        clear_req = 1'b1;
        send(3, 0, 2);
        clear_req = 1'b0;
        check("t4_flush_in_ready", 32'(pix.in_ready), 0);
        for (int i = 0; i < 19200; i++) sb.push_back({15'(i), 3'b000});
        finished  = 0;
        bad_ready = 0;
        bad_busy  = 0;
        for (int n = 0; n < 40000 && !finished; n++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            clear_req = (n == 50);
            tick();
            if (sb.size() == 0) finished = 1;
            else begin
                if (pix.in_ready) bad_ready = 1;
                if (!busy) bad_busy = 1;
            end
        end
        clear_req = 1'b0;
        mem_ready = 1'b1;
        check("t4_clear_done", 32'(finished), 1);
        check("t4_in_ready_low", 32'(bad_ready), 0);
        check("t4_busy_held", 32'(bad_busy), 0);
        check("t4_busy_fall", 32'(busy), 0);
        check("t4_wren_off", 32'(mem_wren), 0);
        tick();
        check("t4_ready_back", 32'(pix.in_ready), 1);

        // reset in the middle of a clear
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 500; i++) sb.push_back({15'(i), 3'b000});
        hit = 0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            tick();
            if (mem_wren && mem_addr == 15'd500) hit = 1;
        end
        check("t5_reached_500", 32'(hit), 1);
        #2 resetn = 1'b0;
        #1;
        check("t5_wren", 32'(mem_wren), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_addr", 32'(mem_addr), 0);
        check("t5_in_ready", 32'(pix.in_ready), 0);
        check("t5_sb_empty", 32'(sb.size()), 0);
        tick();
        tick();
        resetn   = 1'b1;
        exp_drop = 0;
        tick();
        check("t5_ready_after", 32'(pix.in_ready), 1);
        check("t5_idle", 32'(busy), 0);
        check("t5_drop_cleared", 32'(drop_count), 0);

        // random plots against a randomly stalling framebuffer
        done6 = 0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(int'($urandom_range(0, 170)), int'($urandom_range(0, 125)),
                         int'($urandom_range(0, 7)));
                done6 = 1;
            end
            begin
                for (int n = 0; n < 5000 && !done6; n++) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        mem_ready = 1'b1;
        for (int n = 0; n < 100 && busy; n++) tick();
        check("t6_busy", 32'(busy), 0);
        check("t6_sb_empty", 32'(sb.size()), 0);
        check("t6_drop", 32'(drop_count), 32'(exp_drop));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
